// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - 640x480@60 default timing constants, derived positions and polarity helpers
package vga_timing_pkg;

   localparam int H_VISIBLE_D = 640;
   localparam int H_FRONT_D   = 16;
   localparam int H_SYNC_D    = 96;
   localparam int H_BACK_D    = 48;
   localparam int V_VISIBLE_D = 480;
   localparam int V_FRONT_D   = 10;
   localparam int V_SYNC_D    = 2;
   localparam int V_BACK_D    = 33;

   localparam int H_TOTAL_D    = H_VISIBLE_D + H_FRONT_D + H_SYNC_D + H_BACK_D;
   localparam int V_TOTAL_D    = V_VISIBLE_D + V_FRONT_D + V_SYNC_D + V_BACK_D;
   localparam int HS_START_D   = H_VISIBLE_D + H_FRONT_D;
   localparam int HS_END_D     = HS_START_D + H_SYNC_D;
   localparam int VS_START_D   = V_VISIBLE_D + V_FRONT_D;
   localparam int VS_END_D     = VS_START_D + V_SYNC_D;

   localparam int COUNT_W      = 10;
   localparam int COUNT_LIMIT  = 1 << COUNT_W;

   localparam bit POL_ACTIVE_LOW  = 1'b0;
   localparam bit POL_ACTIVE_HIGH = 1'b1;

   // Half-open window test [lo, hi) used by every sync decode.
   function automatic logic in_window(input logic [COUNT_W-1:0] v,
                                      input logic [COUNT_W-1:0] lo,
                                      input logic [COUNT_W-1:0] hi);
      return (v >= lo) && (v < hi);
   endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// rtl/vga_axis_counter.sv - wrap counter with enable and terminal-count flag, resets to TOTAL-1
module vga_axis_counter
   import vga_timing_pkg::*;
#(
   parameter int TOTAL = H_TOTAL_D,
   parameter int W     = COUNT_W
) (
   input  logic         clock,
   input  logic         reset_n,
   input  logic         en,
   output logic [W-1:0] count,
   output logic [W-1:0] count_next,
   output logic         tc
);

   localparam logic [W-1:0] LAST = W'(TOTAL - 1);

   assign tc = (count == LAST);

   // Exposed so the parent can decode flags against the value about to be loaded.
   always_comb begin
      count_next = count;
      if (en) begin
         count_next = tc ? '0 : count + 1'b1;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         count <= LAST;
      end else begin
         count <= count_next;
      end
   end

endmodule

// File: rtl/vga_controlador.sv
// rtl/vga_controlador.sv - VGA timing generator: registered x/y counters with zero-skew hs/vs/video
module vga_controlador
   import vga_timing_pkg::*;
#(
   parameter int H_VISIBLE = H_VISIBLE_D,
   parameter int H_FRONT   = H_FRONT_D,
   parameter int H_SYNC    = H_SYNC_D,
   parameter int H_BACK    = H_BACK_D,
   parameter int V_VISIBLE = V_VISIBLE_D,
   parameter int V_FRONT   = V_FRONT_D,
   parameter int V_SYNC    = V_SYNC_D,
   parameter int V_BACK    = V_BACK_D,
   parameter bit HS_POL    = POL_ACTIVE_LOW,
   parameter bit VS_POL    = POL_ACTIVE_LOW
) (
   input  logic         clock,
   input  logic         reset_n,
   output logic         hs,
   output logic         vs,
   output logic [9:0]   x,
   output logic [9:0]   y,
   output logic         video
);

   localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

   if (H_TOTAL > COUNT_LIMIT || V_TOTAL > COUNT_LIMIT) begin : g_total_check
      $error("vga_controlador: H_TOTAL and V_TOTAL must not exceed 1024");
   end

   localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FRONT);
   localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
   localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FRONT);
   localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);
   localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
   localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);

   logic [9:0] x_next;
   logic [9:0] y_next;
   logic       h_tc;
   logic       v_tc_unused;

   vga_axis_counter #(.TOTAL(H_TOTAL), .W(10)) u_hcount (
      .clock      (clock),
      .reset_n    (reset_n),
      .en         (1'b1),
      .count      (x),
      .count_next (x_next),
      .tc         (h_tc)
   );

   vga_axis_counter #(.TOTAL(V_TOTAL), .W(10)) u_vcount (
      .clock      (clock),
      .reset_n    (reset_n),
      .en         (h_tc),
      .count      (y),
      .count_next (y_next),
      .tc         (v_tc_unused)
   );

   // Flags decode the counters' next values so they land on the same edge as x/y.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         hs    <= ~HS_POL;
         vs    <= ~VS_POL;
         video <= 1'b0;
      end else begin
         hs    <= in_window(x_next, HS_START, HS_END) ? HS_POL : ~HS_POL;
         vs    <= in_window(y_next, VS_START, VS_END) ? VS_POL : ~VS_POL;
         video <= (x_next < H_VIS) && (y_next < V_VIS);
      end
   end

endmodule

// File: tb/tb_vga_controlador.sv
// tb/tb_vga_controlador.sv - self-checking bench: vector table plus frame-level sequences on three instances
module tb_vga_controlador;

   logic clock = 1'b0;
   logic reset_n = 1'b0;

   always #20 clock = ~clock;

   logic       hs_d, vs_d, video_d;
   logic [9:0] x_d, y_d;
   logic       hs_p, vs_p, video_p;
   logic [9:0] x_p, y_p;
   logic       hs_s, vs_s, video_s;
   logic [9:0] x_s, y_s;

   vga_controlador dut (
      .clock(clock), .reset_n(reset_n), .hs(hs_d), .vs(vs_d), .x(x_d), .y(y_d), .video(video_d)
   );

   vga_controlador #(
      .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1), .HS_POL(1'b1), .VS_POL(1'b1)
   ) dut_pol (
      .clock(clock), .reset_n(reset_n), .hs(hs_p), .vs(vs_p), .x(x_p), .y(y_p), .video(video_p)
   );

   vga_controlador #(
      .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
      .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1)
   ) dut_small (
      .clock(clock), .reset_n(reset_n), .hs(hs_s), .vs(vs_s), .x(x_s), .y(y_s), .video(video_s)
   );

   typedef struct {
      int n;
      int x;
      int y;
      int hs;
      int vs;
      int video;
   } vec_t;

   int checks = 0;
   int errors = 0;
   int n = 0;

   int mism_d = 0, mism_p = 0, mism_s = 0;
   int vid_d = 0, hsact_d = 0, vsact_d = 0;
   int vid_p = 0, hsact_p = 0, vsact_p = 0;
   int vid_s = 0, hsact_s = 0, vsact_s = 0;
   int maxx_s = 0, maxy_s = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   // Reference: position is simply the edge count since release folded into the frame.
   task automatic model(input int k, input int ht, input int vt, input int hvis, input int vvis,
                        input int hs0, input int hs1, input int vs0, input int vs1,
                        output int ex, output int ey, output int hact, output int vact,
                        output int evid);
      ex   = k % ht;
      ey   = (k / ht) % vt;
      hact = (ex >= hs0 && ex < hs1) ? 1 : 0;
      vact = (ey >= vs0 && ey < vs1) ? 1 : 0;
      evid = (ex < hvis && ey < vvis) ? 1 : 0;
   endtask

   task automatic check_cycle();
      int ex, ey, ha, va, ev;
      model(n - 1, 800, 525, 640, 480, 656, 752, 490, 492, ex, ey, ha, va, ev);
      if (x_d != 10'(ex) || y_d != 10'(ey) || hs_d != !ha || vs_d != !va || video_d != ev[0]) mism_d++;
      if (n <= 1600) begin
         vid_d += int'(video_d); hsact_d += int'(!hs_d); vsact_d += int'(!vs_d);
      end
      model(n - 1, 800, 8, 640, 4, 656, 752, 5, 7, ex, ey, ha, va, ev);
      if (x_p != 10'(ex) || y_p != 10'(ey) || hs_p != ha[0] || vs_p != va[0] || video_p != ev[0]) mism_p++;
      if (n <= 6400) begin
         vid_p += int'(video_p); hsact_p += int'(hs_p); vsact_p += int'(vs_p);
      end
      model(n - 1, 15, 8, 8, 4, 10, 13, 5, 7, ex, ey, ha, va, ev);
      if (x_s != 10'(ex) || y_s != 10'(ey) || hs_s != !ha || vs_s != !va || video_s != ev[0]) mism_s++;
      if (n <= 120) begin
         vid_s += int'(video_s); hsact_s += int'(!hs_s); vsact_s += int'(!vs_s);
      end
      if (int'(x_s) > maxx_s) maxx_s = int'(x_s);
      if (int'(y_s) > maxy_s) maxy_s = int'(y_s);
   endtask

   task automatic step();
      @(posedge clock);
      #1;
      n++;
      check_cycle();
   endtask

   task automatic run_to(input int target);
      int guard = 0;
      while (n < target && guard < 20000) begin
         step();
         guard++;
      end
      chk("run_to_reached", n, target);
   endtask

   vec_t tbl[11];

   initial begin
      tbl[0]  = '{n: 1,    x: 0,   y: 0, hs: 1, vs: 1, video: 1};
      tbl[1]  = '{n: 640,  x: 639, y: 0, hs: 1, vs: 1, video: 1};
      tbl[2]  = '{n: 641,  x: 640, y: 0, hs: 1, vs: 1, video: 0};
      tbl[3]  = '{n: 656,  x: 655, y: 0, hs: 1, vs: 1, video: 0};
      tbl[4]  = '{n: 657,  x: 656, y: 0, hs: 0, vs: 1, video: 0};
      tbl[5]  = '{n: 752,  x: 751, y: 0, hs: 0, vs: 1, video: 0};
      tbl[6]  = '{n: 753,  x: 752, y: 0, hs: 1, vs: 1, video: 0};
      tbl[7]  = '{n: 800,  x: 799, y: 0, hs: 1, vs: 1, video: 0};
      tbl[8]  = '{n: 801,  x: 0,   y: 1, hs: 1, vs: 1, video: 1};
      tbl[9]  = '{n: 1441, x: 640, y: 1, hs: 1, vs: 1, video: 0};
      tbl[10] = '{n: 1601, x: 0,   y: 2, hs: 1, vs: 1, video: 1};

      reset_n = 1'b0;
      repeat (4) @(posedge clock);
      #1;
      chk("rst_x", int'(x_d), 799);
      chk("rst_y", int'(y_d), 524);
      chk("rst_hs", int'(hs_d), 1);
      chk("rst_vs", int'(vs_d), 1);
      chk("rst_video", int'(video_d), 0);
      chk("rst_pol_hs", int'(hs_p), 0);
      chk("rst_pol_vs", int'(vs_p), 0);
      chk("rst_pol_y", int'(y_p), 7);
      chk("rst_small_x", int'(x_s), 14);

      @(negedge clock);
      reset_n = 1'b1;
      n = 0;

      for (int i = 0; i < 11; i++) begin
         run_to(tbl[i].n);
         chk($sformatf("vec%0d_x", i), int'(x_d), tbl[i].x);
         chk($sformatf("vec%0d_y", i), int'(y_d), tbl[i].y);
         chk($sformatf("vec%0d_hs", i), int'(hs_d), tbl[i].hs);
         chk($sformatf("vec%0d_vs", i), int'(vs_d), tbl[i].vs);
         chk($sformatf("vec%0d_video", i), int'(video_d), tbl[i].video);
      end

      chk("line_video_cnt", vid_d, 1280);
      chk("line_hs_cnt", hsact_d, 192);
      chk("line_vs_cnt", vsact_d, 0);

      chk("small_frame_video", vid_s, 32);
      chk("small_frame_hs", hsact_s, 24);
      chk("small_frame_vs", vsact_s, 30);
      chk("small_max_x", maxx_s, 14);
      chk("small_max_y", maxy_s, 7);

      run_to(6400);
      chk("pol_last_x", int'(x_p), 799);
      chk("pol_last_y", int'(y_p), 7);
      step();
      chk("pol_wrap_x", int'(x_p), 0);
      chk("pol_wrap_y", int'(y_p), 0);
      chk("pol_wrap_video", int'(video_p), 1);
      chk("pol_wrap_hs", int'(hs_p), 0);
      chk("pol_wrap_vs", int'(vs_p), 0);
      chk("pol_frame_video", vid_p, 2560);
      chk("pol_frame_hs", hsact_p, 768);
      chk("pol_frame_vs", vsact_p, 1600);

      run_to(7201);
      chk("pre_rst_x", int'(x_d), 0);
      chk("pre_rst_y", int'(y_d), 9);
      run_to(7501);
      chk("mid_x", int'(x_d), 300);
      #10;
      reset_n = 1'b0;
      #1;
      chk("async_rst_x", int'(x_d), 799);
      chk("async_rst_y", int'(y_d), 524);
      chk("async_rst_video", int'(video_d), 0);
      chk("async_rst_hs", int'(hs_d), 1);
      repeat (2) @(posedge clock);
      #1;
      chk("held_rst_x", int'(x_d), 799);
      @(negedge clock);
      reset_n = 1'b1;
      n = 0;
      step();
      chk("restart_x", int'(x_d), 0);
      chk("restart_y", int'(y_d), 0);
      chk("restart_video", int'(video_d), 1);
      run_to(121);
      chk("small_wrap_x", int'(x_s), 0);
      chk("small_wrap_y", int'(y_s), 0);
      chk("small_wrap_video", int'(video_s), 1);
      chk("small_wrap_hs", int'(hs_s), 1);
      chk("small_wrap_vs", int'(vs_s), 1);

      chk("cycle_mism_default", mism_d, 0);
      chk("cycle_mism_pol", mism_p, 0);
      chk("cycle_mism_small", mism_s, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/vga_controlador.md
Name: vga_controlador

Overview:
- VGA timing generator for 640x480 at 60 Hz, driven by a 25 MHz pixel clock (40 ns period).
- Produces horizontal and vertical sync, the current pixel coordinates, and a visible-area (video) flag.
- Sits between the pixel clock source and the pixel/colour generator, which uses x, y and video to drive RGB.

Parameters:
- H_VISIBLE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (clocks)
- H_SYNC, 96, horizontal sync width (clocks)
- H_BACK, 48, horizontal back porch (clocks)
- V_VISIBLE, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BACK, 33, vertical back porch (lines)
- HS_POL, 0, active level of hs (0 = active-low)
- VS_POL, 0, active level of vs (0 = active-low)

Ports:
- clock  input  1  pixel clock, 25 MHz, rising-edge
- reset_n  input  1  asynchronous active-low reset
- hs  output  1  horizontal sync
- vs  output  1  vertical sync
- x  output  10  current horizontal pixel count, 0..H_TOTAL-1
- y  output  10  current line count, 0..V_TOTAL-1
- video  output  1  high when (x,y) is inside the visible area

Behaviour:
- One clock; reset is asynchronous and active-low.
- Derived constants:
  - H_TOTAL = sum of the four H_* parameters (800 by default).
  - V_TOTAL = sum of the four V_* parameters (525 by default).
  - Both totals must be <= 1024; elaborate-time check.
- All outputs are registered, with no combinational path from inputs to outputs.
- hs, vs and video always describe the pixel currently on x,y (zero skew between the outputs).
- Reset (reset_n low), applied asynchronously and held while low:
  - x = H_TOTAL-1 (799), y = V_TOTAL-1 (524).
  - hs = vs = inactive level (1 by default).
  - video = 0.
  - This is a self-consistent "last pixel of frame" state.
- Each rising edge with reset_n high:
  - If x == H_TOTAL-1: x <= 0, and y <= (y == V_TOTAL-1) ? 0 : y+1.
  - Otherwise x <= x+1 and y holds.
- Decode, applied to the next (x,y) values so the registered flags align with the counters:
  - hs active when H_VISIBLE+H_FRONT <= x < H_VISIBLE+H_FRONT+H_SYNC (656..751 by default).
  - vs active when V_VISIBLE+V_FRONT <= y < V_VISIBLE+V_FRONT+V_SYNC (490..491 by default). vs changes only together with the line wrap at x 799->0.
  - video = (x < H_VISIBLE) && (y < V_VISIBLE).
- First edge after reset release: x=0, y=0, video=1, hs and vs inactive.
- Wrap-around:
  - (799,524) -> (0,0) on a single edge.
  - Counters never exceed H_TOTAL-1 / V_TOTAL-1.
- Reset mid-frame immediately forces the reset state. Counting restarts cleanly from (0,0) on the first edge after release.
- Timing summary (default parameters):
  - line period: 800 clocks
  - frame: 420000 clocks
  - visible pixels per frame: 307200
  - hs pulse: 96 clocks per line
  - vs pulse: 1600 clocks per frame

Decomposition:
- Shared package vga_timing_pkg:
  - default timing constants (the H_*/V_* values above);
  - derived totals and sync start/end positions;
  - polarity constants.
- One sub-module is natural: vga_axis_counter, a parameterised wrap counter with enable, terminal-count flag and reset value TOTAL-1.
  - Instantiated twice: horizontal (enable = 1) and vertical (enable = horizontal terminal count).
- Sync/video decode stays in the top level.

Test Plan:
- Hold reset_n low across several edges -> x=799, y=524, hs=1, vs=1, video=0. Release, then one edge -> x=0, y=0, video=1, hs=1, vs=1.
- Run one line from (0,0):
  - video=1 for x 0..639, 0 for x 640..799;
  - hs=0 exactly for x 656..751 (96 clocks);
  - y increments to 1 on the edge after x=799.
- Run a full frame:
  - vs=0 exactly while y is 490..491 (1600 clocks);
  - exactly 307200 clocks have video=1;
  - frame length is 420000 clocks, returning to (0,0).
- Boundary wrap: at x=799, y=524 the next edge gives x=0, y=0, video=1, hs=1, vs=1. The counters never reach 800 or 525.
- Assert reset_n low mid-line (e.g. x=300, y=200) between clock edges -> outputs jump to the reset state immediately, without waiting for a clock edge. Release -> next edge gives (0,0).
- Override HS_POL=1, VS_POL=1 -> hs high only for x 656..751 and vs high only for y 490..491. The reset value of hs and vs is 0.
